// File: rtl/reimu_defs.sv
// Shared definitions for Reimu's collision logic: default geometry and
// the scanner state encodings.
package reimu_defs;

  localparam int NUM_BULLETS_DEF = 16;
  localparam int COORD_W_DEF     = 10;
  localparam int HIT_R_DEF       = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

endpackage

// File: rtl/hitbox_cmp.sv
// Square hitbox test between a point (bx,by) and a centre (px,py).
// Differences are taken one bit wider than the coordinates so values near
// 0 and near the top of the range never wrap into each other.
module hitbox_cmp
  import reimu_defs::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int HIT_R   = HIT_R_DEF
) (
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  input  logic               valid,
  output logic               hit
);

  localparam logic [COORD_W:0] RADIUS = (COORD_W+1)'(HIT_R);

  logic signed [COORD_W:0] dx;
  logic signed [COORD_W:0] dy;
  logic        [COORD_W:0] adx;
  logic        [COORD_W:0] ady;

  // Signed distance, magnitude, then box test on both axes.
  always_comb begin
    dx  = $signed({1'b0, bx}) - $signed({1'b0, px});
    dy  = $signed({1'b0, by}) - $signed({1'b0, py});
    adx = dx[COORD_W] ? $unsigned(-dx) : $unsigned(dx);
    ady = dy[COORD_W] ? $unsigned(-dy) : $unsigned(dy);
    hit = valid && (adx <= RADIUS) && (ady <= RADIUS);
  end

endmodule

// File: rtl/reimu_hit_detect.sv
// Per-frame enemy-bullet collision scanner. On a frame start (while Reimu
// is alive) it reads every bullet-table slot once, frees each slot whose
// bullet overlaps the hitbox, and reports a single shot pulse per frame.
// Read data returns one cycle after the read strobe, so comparisons run one
// cycle behind the address; the free pulse is registered, adding another
// cycle, which is why DRAIN lasts two cycles before REPORT.
module reimu_hit_detect
  import reimu_defs::*;
#(
  parameter int NUM_BULLETS = NUM_BULLETS_DEF,
  parameter int COORD_W     = COORD_W_DEF,
  parameter int HIT_R       = HIT_R_DEF,
  localparam int AW         = $clog2(NUM_BULLETS)
) (
  input  logic               clk_22,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] reimu_x,
  input  logic [COORD_W-1:0] reimu_y,
  input  logic               reimu_alive,
  output logic               bl_rd,
  output logic [AW-1:0]      bl_addr,
  input  logic               bl_valid,
  input  logic [COORD_W-1:0] bl_x,
  input  logic [COORD_W-1:0] bl_y,
  output logic               hit_clr,
  output logic [AW-1:0]      hit_addr,
  output logic               shot,
  output logic               busy
);

  localparam logic [AW-1:0] LAST_SLOT = AW'(NUM_BULLETS - 1);

  state_t             state_q, state_d;
  logic [AW-1:0]      cnt_q, cnt_d;
  logic               drain_q, drain_d;
  logic               hit_flag_q, hit_flag_d;
  logic               cmp_en_q;
  logic [AW-1:0]      rd_addr_q;
  logic               hit_clr_q, hit_clr_d;
  logic [AW-1:0]      hit_addr_q, hit_addr_d;
  logic [COORD_W-1:0] px_q, px_d;
  logic [COORD_W-1:0] py_q, py_d;
  logic               cmp_hit;
  logic               slot_hit;

  hitbox_cmp #(
    .COORD_W (COORD_W),
    .HIT_R   (HIT_R)
  ) u_cmp (
    .px    (px_q),
    .py    (py_q),
    .bx    (bl_x),
    .by    (bl_y),
    .valid (bl_valid),
    .hit   (cmp_hit)
  );

  // Control state: FSM, scan counter, compare pipeline and hit bookkeeping.
  always_ff @(posedge clk_22) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      drain_q    <= 1'b0;
      hit_flag_q <= 1'b0;
      cmp_en_q   <= 1'b0;
      hit_clr_q  <= 1'b0;
      hit_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      drain_q    <= drain_d;
      hit_flag_q <= hit_flag_d;
      cmp_en_q   <= (state_q == ST_SCAN);
      hit_clr_q  <= hit_clr_d;
      hit_addr_q <= hit_addr_d;
    end
  end

  // Datapath registers: latched player position and delayed read address.
  always_ff @(posedge clk_22) begin
    px_q      <= px_d;
    py_q      <= py_d;
    rd_addr_q <= cnt_q;
  end

  // Next-state logic, hit handling and output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    drain_d    = 1'b0;
    hit_flag_d = hit_flag_q;
    px_d       = px_q;
    py_d       = py_q;
    slot_hit   = cmp_en_q && cmp_hit;
    hit_clr_d  = slot_hit;
    hit_addr_d = slot_hit ? rd_addr_q : hit_addr_q;

    if (slot_hit) begin
      hit_flag_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (frame_start && reimu_alive) begin
          px_d       = reimu_x;
          py_d       = reimu_y;
          hit_flag_d = 1'b0;
          state_d    = ST_SCAN;
        end
      end
      ST_SCAN: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == LAST_SLOT) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          drain_d = 1'b0;
          state_d = ST_REPORT;
        end
      end
      ST_REPORT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    bl_rd    = (state_q == ST_SCAN);
    bl_addr  = cnt_q;
    busy     = (state_q != ST_IDLE);
    shot     = (state_q == ST_REPORT) && hit_flag_q;
    hit_clr  = hit_clr_q;
    hit_addr = hit_addr_q;
  end

endmodule

// File: tb/tb_reimu_hit_detect.sv
// Bench for reimu_hit_detect: a registered bullet-table model answers reads,
// and every cycle of each frame is compared against timing and hit sets
// derived directly from the box rule with integer arithmetic.
module tb_reimu_hit_detect;

  localparam int N = 16;

  logic       clk_22 = 1'b0;
  logic       rst_n;
  logic       frame_start;
  logic [9:0] reimu_x;
  logic [9:0] reimu_y;
  logic       reimu_alive;
  logic       bl_rd;
  logic [3:0] bl_addr;
  logic       bl_valid;
  logic [9:0] bl_x;
  logic [9:0] bl_y;
  logic       hit_clr;
  logic [3:0] hit_addr;
  logic       shot;
  logic       busy;

  logic       tv [N];
  logic [9:0] tx [N];
  logic [9:0] ty [N];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk_22 = ~clk_22;

  reimu_hit_detect dut (
    .clk_22      (clk_22),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .reimu_x     (reimu_x),
    .reimu_y     (reimu_y),
    .reimu_alive (reimu_alive),
    .bl_rd       (bl_rd),
    .bl_addr     (bl_addr),
    .bl_valid    (bl_valid),
    .bl_x        (bl_x),
    .bl_y        (bl_y),
    .hit_clr     (hit_clr),
    .hit_addr    (hit_addr),
    .shot        (shot),
    .busy        (busy)
  );

  // Bullet table: data appears one cycle after the read strobe.
  always @(posedge clk_22) begin
    if (bl_rd) begin
      bl_valid <= tv[bl_addr];
      bl_x     <= tx[bl_addr];
      bl_y     <= ty[bl_addr];
    end else begin
      bl_valid <= 1'b0;
      bl_x     <= 10'($urandom);
      bl_y     <= 10'($urandom);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic bit ref_hit(input int px, input int py, input int bx, input int by, input bit v);
    return v && (iabs(bx - px) <= 4) && (iabs(by - py) <= 4);
  endfunction

  function automatic int clip(input int v);
    return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
  endfunction

  task automatic clear_table();
    for (int i = 0; i < N; i++) begin
      tv[i] = 1'b0;
      tx[i] = 10'($urandom);
      ty[i] = 10'($urandom);
    end
  endtask

  task automatic set_slot(input int i, input int x, input int y);
    tv[i] = 1'b1;
    tx[i] = 10'(x);
    ty[i] = 10'(y);
  endtask

  // One frame observed from frame start: cycle k=1 is the first cycle after
  // the edge that samples frame_start. Optional disturbance re-pulses
  // frame_start, scrambles the player position and drops reimu_alive.
  task automatic run_frame(input string name, input int px, input int py,
                           input bit alive, input bit disturb);
    bit exp_hit [N];
    bit any_hit;
    bit exp_busy, exp_rd, exp_clr, exp_shot;
    int slot;
    any_hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      exp_hit[i] = ref_hit(px, py, int'(tx[i]), int'(ty[i]), tv[i]);
      any_hit    = any_hit | exp_hit[i];
    end
    reimu_x     = 10'(px);
    reimu_y     = 10'(py);
    reimu_alive = alive;
    @(negedge clk_22);
    frame_start = 1'b1;
    @(negedge clk_22);
    frame_start = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      slot     = k - 3;
      exp_busy = alive && (k <= 19);
      exp_rd   = alive && (k <= 16);
      exp_clr  = alive && (slot >= 0) && (slot < N) && exp_hit[(slot >= 0 && slot < N) ? slot : 0];
      exp_shot = alive && (k == 19) && any_hit;
      chk({name, ".busy"}, 32'(busy), 32'(exp_busy));
      chk({name, ".bl_rd"}, 32'(bl_rd), 32'(exp_rd));
      if (exp_rd) chk({name, ".bl_addr"}, 32'(bl_addr), 32'(k - 1));
      chk({name, ".hit_clr"}, 32'(hit_clr), 32'(exp_clr));
      if (exp_clr) chk({name, ".hit_addr"}, 32'(hit_addr), 32'(slot));
      chk({name, ".shot"}, 32'(shot), 32'(exp_shot));
      if (disturb) begin
        reimu_x = 10'($urandom);
        reimu_y = 10'($urandom);
        if (k == 4) reimu_alive = 1'b0;
        frame_start = (k == 5) || (k == 11);
      end
      @(negedge clk_22);
    end
    frame_start = 1'b0;
    reimu_alive = 1'b1;
  endtask

  initial begin
    int px, py, x, y;
    rst_n       = 1'b0;
    frame_start = 1'b0;
    reimu_x     = '0;
    reimu_y     = '0;
    reimu_alive = 1'b1;
    clear_table();
    repeat (3) @(negedge clk_22);

    // Reset state.
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.bl_rd", 32'(bl_rd), 32'd0);
    chk("rst.bl_addr", 32'(bl_addr), 32'd0);
    chk("rst.hit_clr", 32'(hit_clr), 32'd0);
    chk("rst.hit_addr", 32'(hit_addr), 32'd0);
    chk("rst.shot", 32'(shot), 32'd0);
    rst_n = 1'b1;
    @(negedge clk_22);

    // Empty table.
    clear_table();
    run_frame("empty", 200, 300, 1'b1, 1'b0);

    // Single corner hit in slot 5.
    clear_table();
    set_slot(5, 204, 296);
    run_frame("slot5", 200, 300, 1'b1, 1'b0);

    // Just outside in x, and an invalid slot sitting on the centre.
    clear_table();
    set_slot(5, 205, 300);
    tv[9] = 1'b0; tx[9] = 10'd200; ty[9] = 10'd300;
    run_frame("miss", 200, 300, 1'b1, 1'b0);

    // Three hits, one shot.
    clear_table();
    set_slot(0, 200, 300);
    set_slot(7, 200, 300);
    set_slot(15, 200, 300);
    run_frame("three", 200, 300, 1'b1, 1'b0);

    // No wrap near the coordinate extremes, and a hit at the origin.
    clear_table();
    set_slot(3, 1020, 1020);
    run_frame("nowrap", 2, 2, 1'b1, 1'b0);
    clear_table();
    set_slot(12, 4, 4);
    run_frame("origin", 0, 0, 1'b1, 1'b0);

    // Dead player: frame start ignored.
    clear_table();
    set_slot(2, 100, 100);
    run_frame("dead", 100, 100, 1'b0, 1'b0);

    // Randomized frames, half of them disturbed mid-scan.
    for (int r = 0; r < 8; r++) begin
      px = int'($urandom_range(0, 1023));
      py = int'($urandom_range(0, 1023));
      clear_table();
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          if ($urandom_range(0, 3) == 0) begin
            x = int'($urandom_range(0, 1023));
            y = int'($urandom_range(0, 1023));
          end else begin
            x = clip(px + int'($urandom_range(0, 12)) - 6);
            y = clip(py + int'($urandom_range(0, 12)) - 6);
          end
          set_slot(i, x, y);
        end
      end
      run_frame("rand", px, py, 1'b1, r[0]);
    end

    // Reset in the middle of a scan with every slot hitting.
    clear_table();
    for (int i = 0; i < N; i++) set_slot(i, 100, 100);
    reimu_x = 10'd100;
    reimu_y = 10'd100;
    @(negedge clk_22);
    frame_start = 1'b1;
    @(negedge clk_22);
    frame_start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk("midrst.busy", 32'(busy), 32'd1);
      frame_start = (k == 5);
      if (k == 8) rst_n = 1'b0;
      @(negedge clk_22);
    end
    frame_start = 1'b0;
    chk("midrst.after.busy", 32'(busy), 32'd0);
    chk("midrst.after.bl_rd", 32'(bl_rd), 32'd0);
    chk("midrst.after.bl_addr", 32'(bl_addr), 32'd0);
    chk("midrst.after.hit_clr", 32'(hit_clr), 32'd0);
    chk("midrst.after.hit_addr", 32'(hit_addr), 32'd0);
    chk("midrst.after.shot", 32'(shot), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk_22);
      chk("postrst.busy", 32'(busy), 32'd0);
      chk("postrst.bl_rd", 32'(bl_rd), 32'd0);
      chk("postrst.hit_clr", 32'(hit_clr), 32'd0);
      chk("postrst.shot", 32'(shot), 32'd0);
    end

    // Normal operation resumes after the reset.
    run_frame("resume", 100, 100, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
